// File: rtl/perceptron_sequencer.sv
// perceptron_sequencer
// Drive side of the perceptron stream interface. Holds one neuron's weights,
// inputs, bias and activation select. On start it streams the (w, x) pairs
// with a 1-based element counter. It then waits for the fixed perceptron
// latency, captures p_data_out into result and pulses done.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   cfg_we/sel/addr/data  register-file write port (sel 0 = weights, 1 = inputs)
//   bias_in, act_in       bias / activation select, latched on start
//   start                 single-cycle pulse, begins one evaluation
//   busy, done, result    status and captured neuron output
//   p_counter, p_w, p_x,
//   p_b, p_act            stream outputs to the perceptron
//   p_data_out            perceptron output
module perceptron_sequencer #(
  parameter int N_INPUTS       = 5,
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 3,
  parameter int RESULT_LATENCY = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic              cfg_sel,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [DATA_W-1:0] bias_in,
  input  logic              act_in,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [31:0]       p_counter,
  output logic [DATA_W-1:0] p_w,
  output logic [DATA_W-1:0] p_x,
  output logic [DATA_W-1:0] p_b,
  output logic              p_act,
  input  logic [DATA_W-1:0] p_data_out
);

  // Latency counter runs from the start edge; capture happens when it has
  // seen RESULT_LATENCY+N_INPUTS-1 further edges, so it never needs to wrap.
  localparam int LAT_W   = $clog2(RESULT_LATENCY + N_INPUTS + 1);
  localparam int CAP_CNT = RESULT_LATENCY + N_INPUTS - 2;

  typedef enum logic [1:0] {IDLE, STREAM, WAIT, DONE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   idx;
  logic [LAT_W-1:0]    lat;
  logic [DATA_W-1:0]   wfile [N_INPUTS];
  logic [DATA_W-1:0]   xfile [N_INPUTS];

  logic                addr_ok;
  logic [ADDR_W-1:0]   idx_nxt;

  // Extra bit so the compare still works when 2**ADDR_W == N_INPUTS.
  assign addr_ok = ({1'b0, cfg_addr} < (ADDR_W+1)'(N_INPUTS));
  assign idx_nxt = idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      lat       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      p_counter <= '0;
      p_w       <= '0;
      p_x       <= '0;
      p_b       <= '0;
      p_act     <= 1'b0;
      for (int i = 0; i < N_INPUTS; i++) begin
        wfile[i] <= '0;
        xfile[i] <= '0;
      end
    end else begin
      done <= 1'b0;

      // Writes only land when no evaluation is in flight.
      if (cfg_we && addr_ok && (state == IDLE || state == DONE)) begin
        if (cfg_sel) xfile[cfg_addr] <= cfg_data;
        else         wfile[cfg_addr] <= cfg_data;
      end

      case (state)
        IDLE, DONE: begin
          p_counter <= '0;
          if (start) begin
            state     <= STREAM;
            busy      <= 1'b1;
            idx       <= '0;
            lat       <= '0;
            p_b       <= bias_in;
            p_act     <= act_in;
            p_counter <= 32'd1;
            p_w       <= wfile[0];
            p_x       <= xfile[0];
          end else begin
            state <= IDLE;
          end
        end

        STREAM: begin
          lat <= lat + 1'b1;
          if (32'(idx) == N_INPUTS - 1) begin
            state     <= WAIT;
            p_counter <= '0;
            p_w       <= '0;
            p_x       <= '0;
          end else begin
            idx       <= idx_nxt;
            p_counter <= 32'(idx_nxt) + 32'd1;
            p_w       <= wfile[idx_nxt];
            p_x       <= xfile[idx_nxt];
          end
        end

        WAIT: begin
          lat <= lat + 1'b1;
          if (lat == LAT_W'(CAP_CNT)) begin
            state  <= DONE;
            result <= p_data_out;
            done   <= 1'b1;
            busy   <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_sequencer.sv
// Bench for perceptron_sequencer: stub perceptron plus a result scoreboard.
// Expected result/done-cycle pairs are queued when start is driven and
// popped by a monitor whenever done pulses.
module tb_perceptron_sequencer;
  localparam int N  = 5;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int RL = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we, cfg_sel;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data, bias_in;
  logic          act_in, start;
  logic          busy, done, p_act;
  logic [DW-1:0] result, p_w, p_x, p_b, p_data_out;
  logic [31:0]   p_counter;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] mw [N];
  logic [31:0] mx [N];
  logic [31:0] exp_q [$];
  int          cyc_q [$];

  perceptron_sequencer #(.N_INPUTS(N), .DATA_W(DW), .ADDR_W(AW), .RESULT_LATENCY(RL)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .bias_in(bias_in), .act_in(act_in), .start(start),
    .busy(busy), .done(done), .result(result), .p_counter(p_counter),
    .p_w(p_w), .p_x(p_x), .p_b(p_b), .p_act(p_act), .p_data_out(p_data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub perceptron: accumulates the stream and presents sum(w*x)+b only in
  // the cycle right before the expected capture edge; garbage otherwise.
  logic [31:0] acc;
  int          lat;
  always @(posedge clk) begin
    if (rst) begin
      acc <= 0; lat <= 0;
    end else if (p_counter == 1) begin
      acc <= p_w * p_x; lat <= 1;
    end else begin
      if (p_counter != 0) acc <= acc + p_w * p_x;
      if (lat != 0) lat <= lat + 1;
    end
  end
  assign p_data_out = (lat == RL + N - 2) ? acc + p_b : 32'hBAD0BAD0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at cyc %0d", tag, obs, obs, expv, expv, cyc);
    end
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        chk("result", result, exp_q.pop_front());
        chk("done_cycle", cyc, cyc_q.pop_front());
        chk("busy_in_done", busy, 0);
      end
    end
  end

  // All tasks assume entry at a negedge.
  task automatic cfg_write(input logic sel, input logic [AW-1:0] a, input logic [31:0] d);
    cfg_we = 1; cfg_sel = sel; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 0;
    if (32'(a) < N) begin
      if (sel) mx[a] = d; else mw[a] = d;
    end
  endtask

  task automatic run(input logic [31:0] bias, input bit chk_s);
    logic [31:0] e;
    e = bias;
    for (int i = 0; i < N; i++) e += mw[i] * mx[i];
    bias_in = bias; act_in = bias[0]; start = 1;
    @(posedge clk); #1;
    start = 0;
    exp_q.push_back(e);
    cyc_q.push_back(cyc + N + RL - 1);
    if (chk_s) begin
      for (int i = 0; i < N; i++) begin
        @(negedge clk);
        chk("p_counter", p_counter, i + 1);
        chk("p_w", p_w, mw[i]);
        chk("p_x", p_x, mx[i]);
        chk("busy", busy, 1);
      end
      @(negedge clk);
      chk("p_counter_wait", p_counter, 0);
      chk("p_w_wait", p_w, 0);
      chk("p_x_wait", p_x, 0);
      chk("p_b_hold", p_b, bias);
      chk("p_act_hold", p_act, 32'(bias[0]));
    end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic load_basic();
    for (int i = 0; i < N; i++) cfg_write(0, AW'(i), i + 1);
    for (int i = 0; i < N; i++) cfg_write(1, AW'(i), 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; cfg_we = 0; cfg_sel = 0; cfg_addr = 0; cfg_data = 0;
    bias_in = 32'h55; act_in = 1; start = 1;
    for (int i = 0; i < N; i++) begin mw[i] = 0; mx[i] = 0; end
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_p_counter", p_counter, 0);
    chk("rst_p_b", p_b, 0);
    chk("rst_p_act", p_act, 0);
    start = 0; rst = 0;
    @(negedge clk);

    // Basic run, result 33.
    load_basic();
    run(3, 1);
    wait_done();
    @(negedge clk);
    chk("result_hold", result, 33);
    chk("p_b_after_done", p_b, 3);

    // Stream check, then back-to-back start in the DONE cycle.
    for (int i = 0; i < N; i++) cfg_write(0, AW'(i), i + 16);
    for (int i = 0; i < N; i++) cfg_write(1, AW'(i), i + 32);
    run(0, 1);
    wait_done();
    run(5, 1);
    wait_done();
    @(negedge clk);

    // Start and cfg write ignored while streaming.
    load_basic();
    run(3, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mid_counter3", p_counter, 3);
    start = 1; cfg_we = 1; cfg_sel = 0; cfg_addr = 4; cfg_data = 100;
    @(negedge clk);
    start = 0; cfg_we = 0;
    chk("no_restart", p_counter, 4);
    wait_done();
    @(negedge clk);
    run(3, 1);
    wait_done();
    @(negedge clk);

    // Out-of-range address is dropped.
    cfg_write(0, 3'd6, 99);
    cfg_write(1, 3'd7, 99);
    run(3, 1);
    wait_done();
    @(negedge clk);

    // Reset mid-stream.
    run(9, 0);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_counter", p_counter, 2);
    rst = 1;
    @(negedge clk);
    chk("mrst_counter", p_counter, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_p_w", p_w, 0);
    chk("mrst_p_x", p_x, 0);
    chk("mrst_p_b", p_b, 0);
    chk("mrst_result", result, 0);
    exp_q.delete(); cyc_q.delete();
    for (int i = 0; i < N; i++) begin mw[i] = 0; mx[i] = 0; end
    rst = 0;
    repeat (25) @(negedge clk);
    run(7, 1);
    wait_done();
    @(negedge clk);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
